ifetch_queue: RTL

Instruction-fetch front end for the pipelined RISC-V core. It owns the fetch PC and issues word requests to a latency-tolerant instruction memory over a valid/ready request channel. Returned instructions are buffered in a small in-order prefetch queue. The queue feeds the Fetch→Decode pipeline register with `{instr, pc, pc+4}` and honours the hazard unit's `StallD`. On a taken branch or jump (`PCSrcE`), it flushes the queue and discards in-flight responses.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/ifq_fifo.sv | 68 ++++++
 rtl/ifetch_queue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the instruction-fetch front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One prefetch-queue slot: the fetched word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifq_entry_t;

  // Sequential successor of a word-aligned PC, wrapping modulo 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally. Flush takes priority over push/pop.
module ifq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        push_data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer/occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: fetch PC, credit-limited request issue,
// in-order prefetch queue feeding Decode, redirect flush with response drop.
// Optional macro IFQ_BYPASS_EN: forward a response straight to the outputs
// when the queue is empty.
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   occ, outst;
  logic [CW:0]     inflight;
  logic            req_fire, rsp_keep, bypass;
  logic            q_push, q_pop, q_full, q_empty;
  logic            tag_full, tag_empty;
  logic [XLEN-1:0] tag_head;
  ifq_entry_t      q_head, q_wdata;
  logic            unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];

  // Outstanding requests are exactly the tags awaiting their response.
  assign inflight       = {1'b0, occ} + {1'b0, outst};
  assign imem_req_valid = !reset && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect;

`ifdef IFQ_BYPASS_EN
  assign bypass = rsp_keep && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign q_push  = rsp_keep && !(bypass && !stall);
  assign q_pop   = !q_empty && !stall;
  assign q_wdata = '{instr: imem_rsp_data, pc: tag_head};

  ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (q_push),
    .push_data_i (q_wdata),
    .pop_i       (q_pop),
    .flush_i     (redirect),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (occ)
  );

  // Tags are never flushed: responses to pre-redirect requests still pop them.
  ifq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tags (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (imem_rsp_valid),
    .flush_i     (1'b0),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (outst)
  );

  // Next fetch PC and drop count; redirect overrides normal advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = outst - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = pc_next(fetch_pc_q);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // Fetch PC and drop counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC_A;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Decode-facing outputs: bypassed response, else queue head, else NOP.
  always_comb begin
    instr_valid = 1'b0;
    instr       = NOP_INSTR;
    instr_pc    = RESET_PC;
    if (bypass) begin
      instr_valid = 1'b1;
      instr       = imem_rsp_data;
      instr_pc    = tag_head;
    end else if (!q_empty) begin
      instr_valid = 1'b1;
      instr       = q_head.instr;
      instr_pc    = q_head.pc;
    end
  end

  assign instr_pc4 = pc_next(instr_pc);

  // The credit scheme keeps both FIFOs from overflowing or underflowing.
  assert property (@(posedge clk) disable iff (reset) !(q_push && q_full && !q_pop));
  assert property (@(posedge clk) disable iff (reset) !(req_fire && tag_full));
  assert property (@(posedge clk) disable iff (reset) !(imem_rsp_valid && tag_empty));

endmodule
